// File: rtl/fan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fan_ctrl_pkg
// Shared definitions for the fan tacho meter: default gate/debounce/stall
// parameters, the measurement FSM state encoding and small saturating
// arithmetic helpers used by the counters.
// -----------------------------------------------------------------------------
package fan_ctrl_pkg;

    // Gate window length minus one, in clk cycles (10 ms at 10 MHz).
    localparam logic [16:0] GATE_DIV_DEF        = 17'd99_999;
    // Consecutive stable synchronized samples needed to accept a level change.
    localparam logic [3:0]  DEBOUNCE_CYCLES_DEF = 4'd15;
    // Consecutive zero-count windows before the fan is declared stalled.
    localparam logic [2:0]  STALL_GATES_DEF     = 3'd4;

    typedef enum logic [0:0] {
        ST_DISABLED = 1'b0,
        ST_MEASURE  = 1'b1
    } meter_state_e;

    // Add one to an 8-bit count when inc is set, holding at 255.
    function automatic logic [7:0] sat_add8(input logic [7:0] value, input logic inc);
        logic [7:0] result;
        if (inc && (value != 8'd255)) begin
            result = value + 8'd1;
        end else begin
            result = value;
        end
        return result;
    endfunction

    // Increment a 3-bit count, holding at limit.
    function automatic logic [2:0] sat_inc3(input logic [2:0] value, input logic [2:0] limit);
        logic [2:0] result;
        if (value >= limit) begin
            result = limit;
        end else begin
            result = value + 3'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fan_tacho_meter_if.sv
// -----------------------------------------------------------------------------
// fan_tacho_meter_if
// Measurement result bus between the tacho meter core and its consumer
// (the fan controller).
//   ena   : measurement enable, driven by the consumer
//   speed : pulses counted in the last completed window (saturated at 255)
//   valid : one-cycle strobe marking a new speed value
//   stall : fan-stalled flag, updated together with valid
// master = meter side (produces results), slave = controller side.
// -----------------------------------------------------------------------------
interface fan_tacho_meter_if;
    logic       ena;
    logic [7:0] speed;
    logic       valid;
    logic       stall;

    modport master (
        input  ena,
        output speed,
        output valid,
        output stall
    );

    modport slave (
        output ena,
        input  speed,
        input  valid,
        input  stall
    );
endinterface

// File: rtl/fan_tacho_meter_core.sv
// -----------------------------------------------------------------------------
// fan_tacho_meter_core
// Gate-window pulse counter with stall detection and enable FSM.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   rise_i : one-cycle count pulse from the tacho conditioner
//   bus    : result bus (master side): ena in; speed, valid, stall out
// A window is GATE_DIV+1 cycles long; in its last cycle (gate-end) the count,
// including a pulse arriving in that very cycle, is published one clk later.
// -----------------------------------------------------------------------------
module fan_tacho_meter_core
    import fan_ctrl_pkg::*;
#(
    parameter logic [16:0] GATE_DIV    = GATE_DIV_DEF,
    parameter logic [2:0]  STALL_GATES = STALL_GATES_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      rise_i,
    fan_tacho_meter_if.master         bus
);

    meter_state_e r_state;
    logic [16:0]  r_gate_cnt;
    logic [7:0]   r_pulse_cnt;
    logic [2:0]   r_zero_cnt;
    logic [7:0]   r_speed;
    logic         r_valid;
    logic         r_stall;

    logic         w_gate_end;
    logic [7:0]   w_win_count;
    logic [2:0]   w_zero_next;

    // Closing-window values: count including a same-cycle pulse, next zero run
    always_comb begin
        w_gate_end  = (r_gate_cnt == GATE_DIV);
        w_win_count = sat_add8(r_pulse_cnt, rise_i);
        if (w_win_count == 8'd0) begin
            w_zero_next = sat_inc3(r_zero_cnt, STALL_GATES);
        end else begin
            w_zero_next = 3'd0;
        end
    end

    // Measurement FSM with gate, pulse and zero-window counters and outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_DISABLED;
            r_gate_cnt  <= 17'd0;
            r_pulse_cnt <= 8'd0;
            r_zero_cnt  <= 3'd0;
            r_speed     <= 8'd0;
            r_valid     <= 1'b0;
            r_stall     <= 1'b0;
        end else begin
            case (r_state)
                ST_DISABLED: begin
                    // Counters parked at 0 so re-entry starts a fresh window;
                    // speed and stall keep the last published result.
                    r_gate_cnt  <= 17'd0;
                    r_pulse_cnt <= 8'd0;
                    r_zero_cnt  <= 3'd0;
                    r_valid     <= 1'b0;
                    if (bus.ena) begin
                        r_state <= ST_MEASURE;
                    end else begin
                        r_state <= ST_DISABLED;
                    end
                end
                ST_MEASURE: begin
                    if (!bus.ena) begin
                        r_state     <= ST_DISABLED;
                        r_gate_cnt  <= 17'd0;
                        r_pulse_cnt <= 8'd0;
                        r_zero_cnt  <= 3'd0;
                        r_valid     <= 1'b0;
                    end else if (w_gate_end) begin
                        // A pulse coinciding with gate end belongs to the
                        // closing window; the new window starts from zero.
                        r_gate_cnt  <= 17'd0;
                        r_pulse_cnt <= 8'd0;
                        r_speed     <= w_win_count;
                        r_valid     <= 1'b1;
                        r_zero_cnt  <= w_zero_next;
                        r_stall     <= (w_zero_next == STALL_GATES);
                    end else begin
                        r_gate_cnt  <= r_gate_cnt + 17'd1;
                        r_pulse_cnt <= sat_add8(r_pulse_cnt, rise_i);
                        r_valid     <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_DISABLED;
                    r_gate_cnt  <= 17'd0;
                    r_pulse_cnt <= 8'd0;
                    r_zero_cnt  <= 3'd0;
                    r_valid     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.speed = r_speed;
    assign bus.valid = r_valid;
    assign bus.stall = r_stall;

endmodule

// File: rtl/tacho_debounce.sv
// -----------------------------------------------------------------------------
// tacho_debounce
// Conditions the raw open-collector tacho input: 2-flop synchronizer, a
// stability filter and a rising-edge detector on the filtered level.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   tacho_i : raw tacho pulse, asynchronous to clk
//   rise_o  : one-cycle pulse per accepted rising edge of the filtered level
// -----------------------------------------------------------------------------
module tacho_debounce
    import fan_ctrl_pkg::*;
#(
    parameter logic [3:0] DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tacho_i,
    output logic rise_o
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_level;
    logic       r_rise;
    logic [3:0] r_stab_cnt;

    logic       w_differs;
    logic       w_accept;
    logic [4:0] w_stab_next;

    // Accept a new level on the differing sample that completes the stable run;
    // a threshold of 0 behaves like 1 (accept on the first differing sample).
    always_comb begin
        w_differs   = r_sync2 ^ r_level;
        w_stab_next = {1'b0, r_stab_cnt} + 5'd1;
        if (w_differs && (w_stab_next >= {1'b0, DEBOUNCE_CYCLES})) begin
            w_accept = 1'b1;
        end else begin
            w_accept = 1'b0;
        end
    end

    // Two-flop synchronizer for the asynchronous tacho input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= tacho_i;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter, filtered level and registered rising-edge pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level    <= 1'b0;
            r_stab_cnt <= 4'd0;
            r_rise     <= 1'b0;
        end else if (w_accept) begin
            r_level    <= r_sync2;
            r_stab_cnt <= 4'd0;
            // The level flips to r_sync2, so a new level of 1 is a rising edge.
            r_rise     <= r_sync2;
        end else if (w_differs) begin
            r_stab_cnt <= w_stab_next[3:0];
            r_rise     <= 1'b0;
        end else begin
            // Any sample agreeing with the filtered level restarts the run.
            r_stab_cnt <= 4'd0;
            r_rise     <= 1'b0;
        end
    end

    assign rise_o = r_rise;

endmodule

// File: rtl/fan_tacho_meter.sv
// -----------------------------------------------------------------------------
// fan_tacho_meter
// Fan tachometer: counts debounced tacho rising edges per gate window and
// reports the count, a new-value strobe and a stall flag.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   ena     : measurement enable
//   tacho_i : raw open-collector tacho pulse, asynchronous to clk
//   speed_o : pulses in the last completed window, saturated at 255
//   valid_o : one-cycle strobe marking a new speed_o value
//   stall_o : fan-stalled flag (STALL_GATES consecutive zero windows)
// -----------------------------------------------------------------------------
module fan_tacho_meter
    import fan_ctrl_pkg::*;
#(
    parameter logic [16:0] GATE_DIV        = GATE_DIV_DEF,
    parameter logic [3:0]  DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter logic [2:0]  STALL_GATES     = STALL_GATES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       tacho_i,
    output logic [7:0] speed_o,
    output logic       valid_o,
    output logic       stall_o
);

    logic w_rise;

    fan_tacho_meter_if u_bus ();

    tacho_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .rst_n   (rst_n),
        .tacho_i (tacho_i),
        .rise_o  (w_rise)
    );

    fan_tacho_meter_core #(
        .GATE_DIV    (GATE_DIV),
        .STALL_GATES (STALL_GATES)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .rise_i (w_rise),
        .bus    (u_bus.master)
    );

    assign u_bus.ena = ena;
    assign speed_o   = u_bus.speed;
    assign valid_o   = u_bus.valid;
    assign stall_o   = u_bus.stall;

endmodule

// File: tb/tb_fan_tacho_meter.sv
// -----------------------------------------------------------------------------
// tb_fan_tacho_meter
// Directed bench. DUT1: GATE_DIV=99, DEBOUNCE_CYCLES=3, STALL_GATES=2.
// DUT2: GATE_DIV=999, DEBOUNCE_CYCLES=1 (saturation with 300 edges/window).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// A tacho level first captured at posedge m yields a count pulse visible
// after posedge m+4 (DUT1). Window w (relative to enable/release) counts
// pulses visible after posedges 100(w-1)+1 .. 100w; valid_o after 100w+1.
// -----------------------------------------------------------------------------
module tb_fan_tacho_meter;

    localparam int K_CLEAN  = 0;
    localparam int K_GLITCH = 1;
    localparam int K_EDGE   = 2;

    logic clk;
    logic rst_n;
    logic tacho1;
    logic tacho2;

    fan_tacho_meter_if u_if1 ();
    fan_tacho_meter_if u_if2 ();

    int tests;
    int fails;
    int abs_cnt;
    int rel_cnt;
    int rec_cnt [16];
    int rec_spd [16];
    int rec_stl [16];
    int rec_at  [16];
    int rec_mid [16];
    int d2_cnt;
    int d2_spd;
    int d2_at;

    int exp_spd [1:9] = '{10, 10, 0, 0, 0, 1, 3, 0, 2};
    int exp_stl [1:9] = '{0, 0, 0, 1, 1, 0, 0, 0, 0};

    fan_tacho_meter #(
        .GATE_DIV        (17'd99),
        .DEBOUNCE_CYCLES (4'd3),
        .STALL_GATES     (3'd2)
    ) u_dut1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (u_if1.ena),
        .tacho_i (tacho1),
        .speed_o (u_if1.speed),
        .valid_o (u_if1.valid),
        .stall_o (u_if1.stall)
    );

    fan_tacho_meter #(
        .GATE_DIV        (17'd999),
        .DEBOUNCE_CYCLES (4'd1),
        .STALL_GATES     (3'd2)
    ) u_dut2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (u_if2.ena),
        .tacho_i (tacho2),
        .speed_o (u_if2.speed),
        .valid_o (u_if2.valid),
        .stall_o (u_if2.stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_rec();
        for (int k = 0; k < 16; k++) begin
            rec_cnt[k] = 0;
            rec_spd[k] = -1;
            rec_stl[k] = -1;
            rec_at[k]  = -1;
            rec_mid[k] = -1;
        end
        rel_cnt = 0;
    endtask

    // One clock: drive DUT2's 300-pulse burst, advance to the falling edge,
    // then record strobes of both DUTs.
    task automatic step();
        int w;
        tacho2 = (abs_cnt < 600) && ((abs_cnt % 2) == 0);
        @(negedge clk);
        abs_cnt++;
        rel_cnt++;
        if (u_if1.valid === 1'b1) begin
            w = (rel_cnt - 1) / 100;
            if (w < 16) begin
                rec_cnt[w]++;
                rec_spd[w] = int'(u_if1.speed);
                rec_stl[w] = int'(u_if1.stall);
                rec_at[w]  = rel_cnt;
            end
        end
        if (((rel_cnt % 100) == 50) && ((rel_cnt / 100) < 16)) begin
            rec_mid[rel_cnt / 100] = int'(u_if1.speed);
        end
        if (u_if2.valid === 1'b1) begin
            d2_cnt++;
            d2_spd = int'(u_if2.speed);
            d2_at  = abs_cnt;
        end
    endtask

    // Run len cycles of a tacho pattern: n pulses of 4 high / 4 low (clean),
    // n 2-cycle glitches (glitch), or n clean pulses plus one pulse timed so
    // its count pulse lands on the gate-end cycle (edge).
    task automatic run_steps(input int kind, input int n, input int len);
        for (int i = 0; i < len; i++) begin
            case (kind)
                K_CLEAN:  tacho1 = (i < 8 * n) && ((i % 8) < 4);
                K_GLITCH: tacho1 = (i < 8 * n) && ((i % 8) < 2);
                K_EDGE:   tacho1 = ((i < 8 * n) && ((i % 8) < 4)) || ((i >= 95) && (i <= 98));
                default:  tacho1 = 1'b0;
            endcase
            step();
        end
        tacho1 = 1'b0;
    endtask

    initial begin
        tests     = 0;
        fails     = 0;
        abs_cnt   = 0;
        d2_cnt    = 0;
        d2_spd    = -1;
        d2_at     = -1;
        rst_n     = 1'b0;
        tacho1    = 1'b0;
        tacho2    = 1'b0;
        u_if1.ena = 1'b0;
        u_if2.ena = 1'b0;
        clear_rec();

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_speed", int'(u_if1.speed), 0);
        chk("reset_valid", int'(u_if1.valid), 0);
        chk("reset_stall", int'(u_if1.stall), 0);

        // Release and enable; windows 1..9 back to back
        rst_n     = 1'b1;
        u_if1.ena = 1'b1;
        u_if2.ena = 1'b1;
        abs_cnt   = 0;
        clear_rec();
        run_steps(K_CLEAN,  10, 100);   // w1: 10 clean pulses
        run_steps(K_CLEAN,  10, 100);   // w2: 10 clean pulses
        run_steps(K_GLITCH, 10, 100);   // w3: glitches only -> 0
        run_steps(K_GLITCH, 10, 100);   // w4: glitches only -> 0, stall
        run_steps(K_CLEAN,   0, 100);   // w5: idle -> 0, stall held
        run_steps(K_CLEAN,   1, 100);   // w6: one pulse -> stall clears
        run_steps(K_EDGE,    2, 100);   // w7: 2 pulses + gate-end pulse -> 3
        run_steps(K_CLEAN,   0, 100);   // w8: idle -> 0 (edge not carried over)
        run_steps(K_CLEAN,   2, 100);   // w9: 2 pulses
        step();                          // observe w9 strobe at 901

        chk("w0_no_valid", rec_cnt[0], 0);
        for (int w = 1; w <= 9; w++) begin
            chk($sformatf("w%0d_valid_count", w), rec_cnt[w], 1);
            chk($sformatf("w%0d_valid_time", w), rec_at[w], 100 * w + 1);
            chk($sformatf("w%0d_speed", w), rec_spd[w], exp_spd[w]);
            chk($sformatf("w%0d_stall", w), rec_stl[w], exp_stl[w]);
        end
        for (int w = 1; w <= 8; w++) begin
            chk($sformatf("w%0d_speed_hold", w), rec_mid[w], exp_spd[w]);
        end

        // Disable: no strobes, speed/stall retained, pulses ignored
        u_if1.ena = 1'b0;
        clear_rec();
        run_steps(K_CLEAN, 5, 50);
        chk("dis_no_valid", rec_cnt[0], 0);
        chk("dis_speed_hold", int'(u_if1.speed), 2);
        chk("dis_stall_hold", int'(u_if1.stall), 0);

        // Re-enable: fresh full window of 5 pulses, then 3 pulses
        u_if1.ena = 1'b1;
        clear_rec();
        run_steps(K_CLEAN, 5, 100);
        run_steps(K_CLEAN, 3, 100);
        chk("reen_no_early_valid", rec_cnt[0], 0);
        chk("reen_valid_count", rec_cnt[1], 1);
        chk("reen_valid_time", rec_at[1], 101);
        chk("reen_speed", rec_spd[1], 5);

        // DUT2: 300 rising edges in its first window saturate at 255
        chk("sat_valid_count", d2_cnt, 1);
        chk("sat_valid_time", d2_at, 1001);
        chk("sat_speed", d2_spd, 255);

        // Mid-window reset: outputs clear at once, partial window discarded
        run_steps(K_CLEAN, 0, 50);
        chk("pre_reset_speed", int'(u_if1.speed), 3);
        rst_n = 1'b0;
        #1;
        chk("async_reset_speed", int'(u_if1.speed), 0);
        chk("async_reset_valid", int'(u_if1.valid), 0);
        chk("async_reset_stall", int'(u_if1.stall), 0);
        chk("async_reset_speed_dut2", int'(u_if2.speed), 0);
        run_steps(K_CLEAN, 0, 3);
        rst_n = 1'b1;
        clear_rec();
        run_steps(K_CLEAN, 0, 110);
        chk("post_reset_no_early_valid", rec_cnt[0], 0);
        chk("post_reset_valid_count", rec_cnt[1], 1);
        chk("post_reset_valid_time", rec_at[1], 101);
        chk("post_reset_speed", rec_spd[1], 0);
        chk("post_reset_stall", rec_stl[1], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
